regfile_wb_arbiter: RTL and testbench

Write-back arbiter and load scoreboard that drives the write port of `regfile`. It merges single-cycle ALU results with backpressured load-unit results into one registered write per cycle. It also keeps a per-register busy vector of in-flight loads so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: merges single-cycle ALU results with
// a small FIFO of backpressured load results. It also tracks per-register busy bits for in-flight loads.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid_pi,
    input  logic [4:0]      alu_rd_pi,
    input  logic [XLEN-1:0] alu_data_pi,
    input  logic            mem_valid_pi,
    output logic            mem_ready_po,
    input  logic [4:0]      mem_rd_pi,
    input  logic [XLEN-1:0] mem_data_pi,
    input  logic            issue_valid_pi,
    input  logic [4:0]      issue_rd_pi,
    output logic            we_po,
    output logic [4:0]      destReg_po,
    output logic [XLEN-1:0] writeData_po,
    output logic [31:0]     busy_po,
    output logic            waw_err_po
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [31:0]     busy_q;

    logic            push;
    logic            pop;
    logic            alu_fire;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [31:0]     busy_next;

    // Ready comes from the registered count only, so a pop never raises it in the same cycle.
    assign mem_ready_po = (count < FULL_COUNT);
    assign busy_po      = busy_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        alu_fire  = alu_valid_pi && (alu_rd_pi != 5'd0);
        push      = mem_valid_pi && mem_ready_po;
        pop       = !alu_fire && (count != '0);
        head_rd   = rd_mem[rd_ptr];
        head_data = data_mem[rd_ptr];

        busy_next = busy_q;
        if (pop && (head_rd != 5'd0)) begin
            busy_next[head_rd] = 1'b0;
        end
        // A set applied after the clear lets an issue win over a same-edge retire.
        if (issue_valid_pi && (issue_rd_pi != 5'd0)) begin
            busy_next[issue_rd_pi] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the FIFO storage has no reset; count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mem_rd_pi;
            data_mem[wr_ptr] <= mem_data_pi;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_po        <= 1'b0;
            destReg_po   <= 5'd0;
            writeData_po <= '0;
            busy_q       <= '0;
            waw_err_po   <= 1'b0;
        end else begin
            busy_q <= busy_next;
            if (alu_fire) begin
                we_po        <= 1'b1;
                destReg_po   <= alu_rd_pi;
                writeData_po <= alu_data_pi;
                if (busy_q[alu_rd_pi]) begin
                    waw_err_po <= 1'b1;
                end
            end else if (pop) begin
                // A load aimed at x0 is drained without a write; address and data hold.
                we_po <= (head_rd != 5'd0);
                if (head_rd != 5'd0) begin
                    destReg_po   <= head_rd;
                    writeData_po <= head_data;
                end
            end else begin
                we_po <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) count <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (!reset) busy_po[0] == 1'b0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus hand-written
// sequences for FIFO backpressure and a mid-run reset.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid_pi;
    logic [4:0]  alu_rd_pi;
    logic [31:0] alu_data_pi;
    logic        mem_valid_pi;
    logic        mem_ready_po;
    logic [4:0]  mem_rd_pi;
    logic [31:0] mem_data_pi;
    logic        issue_valid_pi;
    logic [4:0]  issue_rd_pi;
    logic        we_po;
    logic [4:0]  destReg_po;
    logic [31:0] writeData_po;
    logic [31:0] busy_po;
    logic        waw_err_po;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid_pi   (alu_valid_pi),
        .alu_rd_pi      (alu_rd_pi),
        .alu_data_pi    (alu_data_pi),
        .mem_valid_pi   (mem_valid_pi),
        .mem_ready_po   (mem_ready_po),
        .mem_rd_pi      (mem_rd_pi),
        .mem_data_pi    (mem_data_pi),
        .issue_valid_pi (issue_valid_pi),
        .issue_rd_pi    (issue_rd_pi),
        .we_po          (we_po),
        .destReg_po     (destReg_po),
        .writeData_po   (writeData_po),
        .busy_po        (busy_po),
        .waw_err_po     (waw_err_po)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        waw;
        logic        rdy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic alu_v, input logic [4:0] alu_rd, input logic [31:0] alu_data,
        input logic mem_v, input logic [4:0] mem_rd, input logic [31:0] mem_data,
        input logic iss_v, input logic [4:0] iss_rd,
        input logic we, input logic [4:0] dest, input logic [31:0] wdata,
        input logic [31:0] busy, input logic waw, input logic rdy);
        vec_t v;
        v.alu_v = alu_v; v.alu_rd = alu_rd; v.alu_data = alu_data;
        v.mem_v = mem_v; v.mem_rd = mem_rd; v.mem_data = mem_data;
        v.iss_v = iss_v; v.iss_rd = iss_rd;
        v.we = we; v.dest = dest; v.wdata = wdata;
        v.busy = busy; v.waw = waw; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic alu_v, input logic [4:0] alu_rd, input logic [31:0] alu_data,
                         input logic mem_v, input logic [4:0] mem_rd, input logic [31:0] mem_data,
                         input logic iss_v, input logic [4:0] iss_rd);
        alu_valid_pi   = alu_v;
        alu_rd_pi      = alu_rd;
        alu_data_pi    = alu_data;
        mem_valid_pi   = mem_v;
        mem_rd_pi      = mem_rd;
        mem_data_pi    = mem_data;
        issue_valid_pi = iss_v;
        issue_rd_pi    = iss_rd;
    endtask

    function automatic logic [127:0] outs();
        return {56'd0, we_po, destReg_po, writeData_po, busy_po, waw_err_po, mem_ready_po};
    endfunction

    initial begin
        //            alu_v rd    data          mem_v rd    data        iss rd    we dest wdata         busy          waw rdy
        vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      0, 5'd0,  1, 5'd5, 32'hDEADBEEF, 32'h0,        0, 1);
        vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  0, 5'd5, 32'hDEADBEEF, 32'h0,        0, 1);
        vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd7,  0, 5'd5, 32'hDEADBEEF, 32'h80,       0, 1);
        vecs[3]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h1234,   0, 5'd0,  0, 5'd5, 32'hDEADBEEF, 32'h80,       0, 1);
        vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  1, 5'd7, 32'h1234,     32'h0,        0, 1);
        vecs[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  0, 5'd7, 32'h1234,     32'h0,        0, 1);
        vecs[6]  = mk(0, 5'd0,  32'h0,        1, 5'd3,  32'h33,     1, 5'd3,  0, 5'd7, 32'h1234,     32'h8,        0, 1);
        vecs[7]  = mk(1, 5'd0,  32'hFFFF,     0, 5'd0,  32'h0,      0, 5'd0,  1, 5'd3, 32'h33,       32'h0,        0, 1);
        vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h55,     1, 5'd0,  0, 5'd3, 32'h33,       32'h0,        0, 1);
        vecs[9]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  0, 5'd3, 32'h33,       32'h0,        0, 1);
        vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd9,  0, 5'd3, 32'h33,       32'h200,      0, 1);
        vecs[11] = mk(1, 5'd9,  32'h99,       0, 5'd0,  32'h0,      0, 5'd0,  1, 5'd9, 32'h99,       32'h200,      1, 1);
        vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  0, 5'd9, 32'h99,       32'h200,      1, 1);
        vecs[13] = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h9A,     0, 5'd0,  0, 5'd9, 32'h99,       32'h200,      1, 1);
        vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd9,  1, 5'd9, 32'h9A,       32'h200,      1, 1);
        vecs[15] = mk(1, 5'd4,  32'h44,       1, 5'd9,  32'h9B,     0, 5'd0,  1, 5'd4, 32'h44,       32'h200,      1, 1);
        vecs[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  1, 5'd9, 32'h9B,       32'h0,        1, 1);
        vecs[17] = mk(1, 5'd0,  32'h77,       0, 5'd0,  32'h0,      0, 5'd0,  0, 5'd9, 32'h9B,       32'h0,        1, 1);

        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), {56'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_data,
                  vecs[i].mem_v, vecs[i].mem_rd, vecs[i].mem_data,
                  vecs[i].iss_v, vecs[i].iss_rd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {56'd0, vecs[i].we, vecs[i].dest, vecs[i].wdata, vecs[i].busy, vecs[i].waw, vecs[i].rdy});
        end

        // Backpressure: six ALU cycles to x1 while six loads (x10..x15) are offered.
        begin
            int li;
            logic acc;
            logic       exp_we;
            logic [4:0] exp_dest;
            logic       exp_rdy;
            li = 0;
            for (int i = 0; i < 13; i++) begin
                drive(i < 6, 5'd1, 32'h100 + 32'(i),
                      li < 6, 5'(10 + li), 32'hA00 + 32'(10 + li), 0, 5'd0);
                acc = mem_valid_pi && mem_ready_po;
                @(posedge clk);
                if (acc) li++;
                #1;
                exp_we   = (i < 12);
                exp_dest = (i < 6) ? 5'd1 : ((i < 12) ? 5'(10 + i - 6) : 5'd15);
                exp_rdy  = !(i >= 3 && i <= 5);
                check($sformatf("bp%0d", i),
                      {88'd0, we_po, destReg_po, writeData_po, mem_ready_po},
                      {88'd0, exp_we, exp_dest,
                       (i < 6) ? 32'h100 + 32'(i) : 32'hA00 + 32'(exp_dest), exp_rdy});
            end
        end

        // Mid-run reset with three queued loads and their busy bits set.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd2, 32'h2, 1, 5'(20 + i), 32'(20 + i), 1, 5'(20 + i));
            @(posedge clk);
            #1;
        end
        check("pre_reset", {95'd0, we_po, busy_po}, {95'd0, 1'b1, 32'h0070_0000});
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
        reset = 1'b0;
        #1;
        check("async_reset", outs(), {56'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
        @(posedge clk);
        #4;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d", i), {94'd0, we_po, busy_po, mem_ready_po},
                  {94'd0, 1'b0, 32'h0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
